// File: rtl/divider.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : divider
// Brief    : Multi-cycle 32-bit restoring divider (quotient, remainder, flags).
//            Signed support is built when DIVIDER_SIGNED_EN is defined.
// Revision : 1.0 - initial release
// =============================================================================
module divider (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] reg2,
    input  logic [31:0] reg3,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        carry_out,
    output logic        zero_out,
    output logic        neg_out,
    output logic        over_out
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PREP  = 3'd1,
        S_ITER  = 3'd2,
        S_FIXUP = 3'd3,
        S_DONE  = 3'd4
    } t_state;

    t_state      r_state;
    t_state      w_next;

    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_sop;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div0;
    logic        r_over;
    logic [31:0] r_dvd;
    logic [31:0] r_dvs;
    logic [31:0] r_acc;
    logic [4:0]  r_cnt;
    logic [31:0] r_qres;
    logic [31:0] r_rres;

    logic        r_busy;
    logic        r_done;
    logic [31:0] r_quot;
    logic [31:0] r_rem;
    logic        r_carry;
    logic        r_zero;
    logic        r_neg;
    logic        r_ovf;

    logic        w_signed;
    logic        w_accept;
    logic [32:0] w_shift;
    logic [32:0] w_trial;
    logic        w_fit;

`ifdef DIVIDER_SIGNED_EN
    assign w_signed = r_sop;
`else
    // signed_op is still sampled but masked, so every operation is unsigned
    assign w_signed = r_sop & 1'b0;
`endif

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_shift  = {r_acc, r_dvd[31]};
    assign w_trial  = w_shift - {1'b0, r_dvs};
    assign w_fit    = ~w_trial[32];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_PREP;
            S_PREP:  w_next = (r_b == 32'd0) ? S_DONE : S_ITER;
            S_ITER:  if (r_cnt == 5'd0) w_next = S_FIXUP;
            S_FIXUP: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_sop   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div0  <= 1'b0;
            r_over  <= 1'b0;
            r_dvd   <= 32'd0;
            r_dvs   <= 32'd0;
            r_acc   <= 32'd0;
            r_cnt   <= 5'd0;
            r_qres  <= 32'd0;
            r_rres  <= 32'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quot  <= 32'd0;
            r_rem   <= 32'd0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (r_done) begin
                r_busy <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= reg2;
                        r_b   <= reg3;
                        r_sop <= signed_op;
                    end
                end
                S_PREP: begin
                    r_div0  <= (r_b == 32'd0);
                    r_over  <= 1'b0;
                    r_neg_q <= w_signed & (r_a[31] ^ r_b[31]);
                    r_neg_r <= w_signed & r_a[31];
                    // abs(0x80000000) wraps to itself, read as unsigned 2^31
                    r_dvd   <= (w_signed && r_a[31]) ? -r_a : r_a;
                    r_dvs   <= (w_signed && r_b[31]) ? -r_b : r_b;
                    r_acc   <= 32'd0;
                    r_cnt   <= 5'd31;
                    r_qres  <= 32'hffff_ffff;
                    r_rres  <= r_a;
                end
                S_ITER: begin
                    r_acc <= w_fit ? w_trial[31:0] : w_shift[31:0];
                    r_dvd <= {r_dvd[30:0], w_fit};
                    r_cnt <= r_cnt - 5'd1;
                end
                S_FIXUP: begin
                    r_qres <= r_neg_q ? -r_dvd : r_dvd;
                    r_rres <= r_neg_r ? -r_acc : r_acc;
                    r_over <= w_signed && (r_a == 32'h8000_0000) && (r_b == 32'hffff_ffff);
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_quot  <= r_qres;
                    r_rem   <= r_rres;
                    r_carry <= r_div0;
                    r_zero  <= (r_qres == 32'd0);
                    r_neg   <= r_qres[31];
                    r_ovf   <= r_over & ~r_div0;
                end
                default: ;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign carry_out = r_carry;
    assign zero_out  = r_zero;
    assign neg_out   = r_neg;
    assign over_out  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_divider.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module   : tb_divider
// Brief    : Directed self-checking bench for divider.
// Revision : 1.0 - initial release
// =============================================================================
module tb_divider;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        signed_op;
    logic [31:0] reg2;
    logic [31:0] reg3;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        carry_out;
    logic        zero_out;
    logic        neg_out;
    logic        over_out;

    int n_checks = 0;
    int n_fail   = 0;

    divider dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .signed_op (signed_op),
        .reg2      (reg2),
        .reg3      (reg3),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .carry_out (carry_out),
        .zero_out  (zero_out),
        .neg_out   (neg_out),
        .over_out  (over_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clock);
        reg2      = a;
        reg3      = b;
        signed_op = s;
        start     = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [31:0] eq, input logic [31:0] er,
                       input logic [3:0] ef, input int elat);
        int lat;
        start_div(a, b, s);
        wait_done(lat);
        chk({tag, "_lat"},   32'(lat), 32'(elat));
        chk({tag, "_q"},     quotient, eq);
        chk({tag, "_r"},     remainder, er);
        chk({tag, "_flags"}, {28'd0, carry_out, zero_out, neg_out, over_out}, {28'd0, ef});
        chk({tag, "_busy"},  {31'd0, busy}, 32'd1);
        @(posedge clock);
        #1;
        chk({tag, "_pulse"}, {30'd0, done, busy}, 32'd0);
    endtask

    initial begin
        int ndone;
        int first_lat;
        reset_n   = 1'b0;
        start     = 1'b0;
        signed_op = 1'b0;
        reg2      = 32'd0;
        reg3      = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_q",     quotient, 32'd0);
        chk("rst_r",     remainder, 32'd0);
        chk("rst_ctl",   {28'd0, carry_out, zero_out, neg_out, over_out}, 32'd0);
        chk("rst_hs",    {30'd0, busy, done}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // flags order: {carry, zero, neg, over}
        vec("u100_7",  32'd100, 32'd7, 1'b0, 32'h0000_000e, 32'h0000_0002, 4'b0000, 35);
        vec("divzero", 32'h1234_5678, 32'd0, 1'b0, 32'hffff_ffff, 32'h1234_5678, 4'b1010, 2);
        vec("u_min_m1", 32'h8000_0000, 32'hffff_ffff, 1'b0, 32'd0, 32'h8000_0000, 4'b0100, 35);
        vec("u_small", 32'd5, 32'd7, 1'b0, 32'd0, 32'd5, 4'b0100, 35);
        vec("u_beef",  32'hdead_beef, 32'h10, 1'b0, 32'h0dea_dbee, 32'hf, 4'b0000, 35);
`ifdef DIVIDER_SIGNED_EN
        vec("s_m7_2",  32'hffff_fff9, 32'd2, 1'b1, 32'hffff_fffd, 32'hffff_ffff, 4'b0010, 35);
        vec("s_ovf",   32'h8000_0000, 32'hffff_ffff, 1'b1, 32'h8000_0000, 32'd0, 4'b0011, 35);
        vec("s_7_m2",  32'd7, 32'hffff_fffe, 1'b1, 32'hffff_fffd, 32'd1, 4'b0010, 35);
`else
        vec("s_m7_2",  32'hffff_fff9, 32'd2, 1'b1, 32'h7fff_fffc, 32'd1, 4'b0000, 35);
        vec("s_ovf",   32'h8000_0000, 32'hffff_ffff, 1'b1, 32'd0, 32'h8000_0000, 4'b0100, 35);
        vec("s_7_m2",  32'd7, 32'hffff_fffe, 1'b1, 32'd0, 32'd7, 4'b0100, 35);
`endif

        // start pulsed mid-division must be ignored
        start_div(32'd100, 32'd7, 1'b0);
        ndone     = 0;
        first_lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clock);
            #1;
            start = 1'b0;
            if (done) begin
                ndone++;
                if (first_lat == 0) first_lat = k;
                if (ndone == 1) begin
                    chk("ign_q", quotient, 32'h0000_000e);
                    chk("ign_r", remainder, 32'h0000_0002);
                end
            end
            if (k == 10) begin
                reg2  = 32'd55;
                reg3  = 32'd1;
                start = 1'b1;
            end
        end
        chk("ign_ndone", 32'(ndone), 32'd1);
        chk("ign_lat",   32'(first_lat), 32'd35);

        // asynchronous reset in the middle of ITER
        start_div(32'd100, 32'd7, 1'b0);
        repeat (17) @(posedge clock);
        #2;
        chk("mid_busy_pre", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_q",   quotient, 32'd0);
        chk("mid_r",   remainder, 32'd0);
        chk("mid_all", {26'd0, busy, done, carry_out, zero_out, neg_out, over_out}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        vec("u_ff_ff", 32'hffff_ffff, 32'hffff_ffff, 1'b0, 32'd1, 32'd0, 4'b0000, 35);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
